// File: rtl/match_line_pkg.sv
// Shared definitions for both ends of the two-wire match/pulse line.
// Holds the transmitter state encoding, the idle line levels and the bit encoder.
package match_line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } line_state_t;

    localparam logic LINE_IDLE_X1 = 1'b0;
    localparam logic LINE_IDLE_X2 = 1'b1;

    // A one is a match cycle (x1==x2); a zero is a mismatch cycle.
    function automatic logic [1:0] encode_bit(input logic b, input logic phase);
        return b ? {phase, phase} : {phase, ~phase};
    endfunction

endpackage

// File: rtl/match_pulse_tx.sv
// Transmit end of the match/pulse line: serialises one word per valid/ready handshake.
// Ones cost a match cycle plus a guard cycle, zeros a single mismatch cycle.
//
// state | meaning
// IDLE  | lines at idle pattern, ready for a word
// SEND  | current bit is on the line
// GUARD | blind cycle after a match so the receiver can recover
module match_pulse_tx
    import match_line_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x1,
    output logic             x2,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    line_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shift;
    logic [CW-1:0]    count_q, count_d;
    logic             phase_q, phase_d;
    logic             x1_d, x2_d, done_d;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            phase_q <= 1'b0;
            x1      <= LINE_IDLE_X1;
            x2      <= LINE_IDLE_X2;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            phase_q <= phase_d;
            x1      <= x1_d;
            x2      <= x2_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        count_d      = count_q;
        phase_d      = phase_q;
        x1_d         = LINE_IDLE_X1;
        x2_d         = LINE_IDLE_X2;
        done_d       = 1'b0;
        shreg_shift  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shreg_d      = din;
                    count_d      = COUNT_LAST;
                    phase_d      = 1'b0;
                    {x1_d, x2_d} = encode_bit(head_bit(din), 1'b0);
                    state_d      = SEND;
                end
            end
            SEND: begin
                phase_d = ~phase_q;
                if (head_bit(shreg_q)) begin
                    state_d = GUARD;
                end else if (count_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    shreg_d      = shreg_shift;
                    count_d      = count_q - CW'(1);
                    {x1_d, x2_d} = encode_bit(head_bit(shreg_shift), ~phase_q);
                end
            end
            GUARD: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    shreg_d      = shreg_shift;
                    count_d      = count_q - CW'(1);
                    // phase already advanced when leaving SEND
                    {x1_d, x2_d} = encode_bit(head_bit(shreg_shift), phase_q);
                    state_d      = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign din_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_match_pulse_tx.sv
// Bench for match_pulse_tx: MSB-first and LSB-first instances, a line scoreboard
// and a behavioural equality-detect receiver counting y pulses.
module tb_match_pulse_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic [1:0] valid_v, ready_v, x1_v, x2_v, busy_v, done_v;
    int         sel;

    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_cnt = 0;
    int pulses = 0;
    int done_cnt = 0;
    logic prev_m = 1'b0;
    logic prev_y = 1'b0;
    logic [1:0] sb[$];

    typedef struct {
        logic [7:0] w;
        int         sel;
        int         len;
        int         pul;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    match_pulse_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_v[0]), .din_ready(ready_v[0]),
        .x1(x1_v[0]), .x2(x2_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    match_pulse_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_v[1]), .din_ready(ready_v[1]),
        .x1(x1_v[1]), .x2(x2_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [7:0] w, input bit msb);
        logic ph;
        logic b;
        ph = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = msb ? w[7-i] : w[i];
            if (b) begin
                sb.push_back({ph, ph});
                sb.push_back(2'b01);
            end else begin
                sb.push_back({ph, ~ph});
            end
            ph = ~ph;
        end
    endtask

    // Line scoreboard, receiver model and handshake capture
    always @(negedge clk) begin
        logic [1:0] e;
        logic       y;
        if (busy_v[sel]) begin
            busy_cnt++;
            if (sb.size() == 0) chk("line_extra", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("line", {30'd0, x1_v[sel], x2_v[sel]}, {30'd0, e});
            end
        end
        y = prev_m && !prev_y;
        if (y) pulses++;
        prev_m = (x1_v[sel] == x2_v[sel]);
        prev_y = y;
        if (done_v[sel]) done_cnt++;
        if (valid_v[sel] && ready_v[sel] && !rst)
            push_frame(sel == 0 ? din_a : din_b, sel == 0);
    end

    task automatic set_din(input logic [7:0] w);
        if (sel == 0) din_a = w; else din_b = w;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_v[sel] && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_word(input logic [7:0] w, input int len, input int pul, input string name);
        int cyc;
        busy_cnt = 0;
        pulses = 0;
        chk({name, "_ready"}, {31'd0, ready_v[sel]}, 32'd1);
        set_din(w);
        valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        valid_v[sel] = 1'b0;
        set_din(8'($urandom));
        chk({name, "_busy_lat1"}, {31'd0, busy_v[sel]}, 32'd1);
        wait_done(cyc);
        chk({name, "_done_cycle"}, cyc, len + 1);
        chk({name, "_busy_len"}, busy_cnt, len);
        chk({name, "_pulses"}, pulses, pul);
        chk({name, "_sb_empty"}, sb.size(), 0);
        @(posedge clk); #1;
        chk({name, "_done_1cyc"}, {31'd0, done_v[sel]}, 32'd0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{8'hA5, 0, 12, 4};
        vecs[1] = '{8'h00, 0, 8, 0};
        vecs[2] = '{8'hFF, 0, 16, 8};
        vecs[3] = '{8'h3C, 0, 12, 4};
        vecs[4] = '{8'h01, 1, 9, 1};
        vecs[5] = '{8'h80, 1, 9, 1};

        sel = 0;
        rst = 1'b1;
        valid_v = 2'b00;
        din_a = 8'h00;
        din_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lines", {30'd0, x1_v[0], x2_v[0]}, 32'b01);
        chk("rst_ready_busy", {30'd0, ready_v[0], busy_v[0]}, 32'b10);
        chk("rst_done", {31'd0, done_v[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            run_word(vecs[i].w, vecs[i].len, vecs[i].pul, $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // back-to-back with valid held: second word taken in the done cycle
        sel = 0;
        pulses = 0;
        busy_cnt = 0;
        din_a = 8'h81;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        din_a = 8'h01;
        wait_done(cyc);
        chk("b2b_first_done", cyc, 11);
        chk("b2b_ready_in_done", {31'd0, ready_v[0]}, 32'd1);
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        din_a = 8'hFF;
        chk("b2b_second_busy", {31'd0, busy_v[0]}, 32'd1);
        wait_done(cyc);
        chk("b2b_second_done", cyc, 10);
        chk("b2b_busy_total", busy_cnt, 19);
        chk("b2b_pulses", pulses, 3);
        chk("b2b_sb_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        // reset during the third line cycle of 0xFF
        din_a = 8'hFF;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_lines", {30'd0, x1_v[0], x2_v[0]}, 32'b01);
        chk("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
        sb.delete();
        done_cnt = 0;
        pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_no_pulse", pulses, 0);
        chk("mid_rst_ready", {31'd0, ready_v[0]}, 32'd1);
        run_word(8'h01, 9, 1, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
